sdcmd_engine: RTL and testbench

Parametrised SD-card CMD-line engine and successor to the single-mode command controller. It serialises a 48-bit command frame with CRC7 on `sdcmd` and generates `sdclk` from `clk`. It then receives a response of a selectable type: none, 48-bit short, 136-bit long (R2), or short followed by a DAT0 busy wait (R1b). The response CRC7 is checked. It sits between the SD reader/init FSM and the card pins, and shares `sdclk` with the data-path blocks.

---
 rtl/sd_pkg.sv | 36 +++
 rtl/sd_clkgen.sv | 56 +++++
 rtl/sdcmd_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_sdcmd_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared types and helpers for the SD-card CMD-line engine and the
// data-path blocks that share its clock generator.
//   resp_type_e : response type selector (none / short / long / short+busy)
//   state_e     : CMD engine FSM states
//   crc7_step   : one-bit CRC7 update, polynomial x^7 + x^3 + 1
//   SHORT_LEN / LONG_LEN : response frame lengths in bits
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_SHORT = 2'd1,
        RESP_LONG  = 2'd2,
        RESP_BUSY  = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SEND  = 3'd2,
        S_WAIT  = 3'd3,
        S_RECV  = 3'd4,
        S_BUSYW = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam int unsigned SHORT_LEN = 48;
    localparam int unsigned LONG_LEN  = 136;

    // Shift one bit (MSB first) into a CRC7 register.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_i);
        logic fb;
        fb = crc[6] ^ bit_i;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

endpackage

// File: rtl/sd_clkgen.sv
// sd_clkgen: SD clock generator shared by the CMD engine and the data path.
// Ports:
//   clk, rstn  : system clock, asynchronous active-low reset
//   clkdiv     : half period of sdclk minus one, in clk cycles (latched at
//                each period start so a change never produces a short phase)
//   sdclk      : free-running SD clock, low half first
//   fall, rise : one-clk strobes, high in the clk cycle right after sdclk
//                went 1->0 (fall) or 0->1 (rise)
module sd_clkgen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DIV_W-1:0] clkdiv,
    output logic             sdclk,
    output logic             fall,
    output logic             rise
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             sdclk_q;
    logic             fall_q;
    logic             rise_q;

    // Half-period counter, clock phase and edge strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            div_q   <= '0;
            sdclk_q <= 1'b0;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_q   <= '0;
            sdclk_q <= ~sdclk_q;
            fall_q  <= sdclk_q;
            rise_q  <= ~sdclk_q;
            // A new period starts with the low half: pick up the new divider here.
            if (sdclk_q) begin
                div_q <= clkdiv;
            end else begin
                div_q <= div_q;
            end
        end else begin
            cnt_q  <= cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end
    end

    assign sdclk = sdclk_q;
    assign fall  = fall_q;
    assign rise  = rise_q;

endmodule

// File: rtl/sdcmd_engine.sv
// sdcmd_engine: SD-card CMD-line engine. Sends a 48-bit command with CRC7,
// then receives none / short (48) / long (136) response, optionally followed
// by a DAT0 busy wait, and reports CRC, framing and timeout status.
// Ports:
//   rstn, clk  : asynchronous active-low reset, system clock
//   sdclk      : SD clock out; sdcmd: tri-state CMD line; dat0: card DAT0
//   clkdiv     : sdclk half period = clkdiv+1 clk cycles
//   start, precnt, cmd, arg, resp_type : command request and its fields
//   busy, done : transaction in progress, one-clk completion pulse
//   timeout, crcerr, syntaxe : completion flags; resp: response payload
module sdcmd_engine
    import sd_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int RESP_TIMEOUT = 250,
    parameter int BUSY_W       = 24,
    parameter bit CHECK_CRC    = 1'b1
) (
    input  logic             rstn,
    input  logic             clk,
    output logic             sdclk,
    inout  wire              sdcmd,
    input  logic             dat0,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic             start,
    input  logic [15:0]      precnt,
    input  logic [5:0]       cmd,
    input  logic [31:0]      arg,
    input  logic [1:0]       resp_type,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             crcerr,
    output logic             syntaxe,
    output logic [127:0]     resp
);

    localparam logic [BUSY_W-1:0] BUSY_LIM = {{(BUSY_W-1){1'b1}}, 1'b0};

    logic fall_s, rise_s, cmd_in_s, crc_span_s;
    logic [15:0] last_s;

    state_e       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d, pre_q, pre_d;
    logic [BUSY_W-1:0] bcnt_q, bcnt_d;
    logic [5:0]   cmd_q, cmd_d;
    resp_type_e   type_q, type_d;
    logic [39:0]  tx_q, tx_d;
    logic [6:0]   crc_q, crc_d;
    logic         oe_q, oe_d, out_q, out_d;
    logic [127:0] resp_q, resp_d;
    logic         tout_q, tout_d, crcerr_q, crcerr_d, syn_q, syn_d;
    logic         busy_q, done_q;

    sd_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk    (clk),
        .rstn   (rstn),
        .clkdiv (clkdiv),
        .sdclk  (sdclk),
        .fall   (fall_s),
        .rise   (rise_s)
    );

    // Own drive reads back as 1 so the receiver never sees its own bits.
    assign sdcmd      = oe_q ? out_q : 1'bz;
    assign cmd_in_s   = oe_q ? 1'b1 : sdcmd;
    assign last_s     = (type_q == RESP_LONG) ? 16'(LONG_LEN - 1) : 16'(SHORT_LEN - 1);
    // cnt_q is the index of the bit being received (start bit = 0).
    assign crc_span_s = (type_q == RESP_LONG) ? (cnt_q >= 16'd8 && cnt_q < 16'd128)
                                              : (cnt_q < 16'd40);

    // Next-state logic for the command/response FSM and its datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        pre_d    = pre_q;
        cmd_d    = cmd_q;
        type_d   = type_q;
        tx_d     = tx_q;
        crc_d    = crc_q;
        oe_d     = oe_q;
        out_d    = out_q;
        resp_d   = resp_q;
        tout_d   = tout_q;
        crcerr_d = crcerr_q;
        syn_d    = syn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d    = cmd;
                    type_d   = resp_type_e'(resp_type);
                    pre_d    = precnt;
                    tx_d     = {2'b01, cmd, arg};
                    crc_d    = 7'd0;
                    cnt_d    = 16'd0;
                    tout_d   = 1'b0;
                    crcerr_d = 1'b0;
                    syn_d    = 1'b0;
                    state_d  = (precnt == 16'd0) ? S_SEND : S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (fall_s && cnt_q == pre_q - 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = S_SEND;
                end else if (fall_s) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_SEND: begin
                if (fall_s) begin
                    cnt_d = cnt_q + 16'd1;
                    oe_d  = 1'b1;
                    if (cnt_q < 16'd40) begin
                        out_d = tx_q[39];
                        tx_d  = {tx_q[38:0], 1'b0};
                        crc_d = crc7_step(crc_q, tx_q[39]);
                    end else if (cnt_q < 16'd47) begin
                        out_d = crc_q[6];
                        crc_d = {crc_q[5:0], 1'b0};
                    end else if (cnt_q == 16'd47) begin
                        out_d = 1'b1;
                    end else begin
                        // End bit has had its full period: release the line.
                        oe_d    = 1'b0;
                        out_d   = 1'b1;
                        cnt_d   = 16'd0;
                        state_d = (type_q == RESP_NONE) ? S_DONE : S_WAIT;
                    end
                end else begin
                    oe_d = oe_q;
                end
            end
            S_WAIT: begin
                if (rise_s && !cmd_in_s) begin
                    // Start bit: the previous response is discarded only now.
                    cnt_d   = 16'd1;
                    crc_d   = 7'd0;
                    resp_d  = 128'd0;
                    state_d = S_RECV;
                end else if (rise_s && cnt_q == 16'(RESP_TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rise_s) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RECV: begin
                if (rise_s) begin
                    resp_d = {resp_q[126:0], cmd_in_s};
                    cnt_d  = cnt_q + 16'd1;
                    crc_d  = crc_span_s ? crc7_step(crc_q, cmd_in_s) : crc_q;
                    syn_d  = syn_q | ((cnt_q == 16'd1) & cmd_in_s);
                    if (cnt_q == last_s) begin
                        // resp_q holds frame bit f at position f-1 here.
                        syn_d = syn_d | ~cmd_in_s;
                        if (type_q == RESP_LONG) begin
                            resp_d   = {resp_q[126:0], 1'b0};
                            crcerr_d = CHECK_CRC & (crc_q != resp_q[6:0]);
                        end else begin
                            resp_d   = {90'd0, resp_q[44:7]};
                            syn_d    = syn_d | ((resp_q[44:39] != cmd_q) & (resp_q[44:39] != 6'h3F));
                            crcerr_d = CHECK_CRC & (resp_q[44:39] != 6'h3F) & (crc_q != resp_q[6:0]);
                        end
                        cnt_d   = 16'd0;
                        bcnt_d  = '0;
                        state_d = (type_q == RESP_BUSY) ? S_BUSYW : S_DONE;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    resp_d = resp_q;
                end
            end
            S_BUSYW: begin
                if (rise_s && dat0) begin
                    state_d = S_DONE;
                end else if (rise_s && bcnt_q == BUSY_LIM) begin
                    // A timeout hides any response error already recorded.
                    tout_d   = 1'b1;
                    crcerr_d = 1'b0;
                    syn_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (rise_s) begin
                    bcnt_d = bcnt_q + {{(BUSY_W-1){1'b0}}, 1'b1};
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; done/busy derive from the next state so
    // they line up with the DONE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bcnt_q   <= '0;
            pre_q    <= 16'd0;
            cmd_q    <= 6'd0;
            type_q   <= RESP_NONE;
            tx_q     <= 40'd0;
            crc_q    <= 7'd0;
            oe_q     <= 1'b0;
            out_q    <= 1'b1;
            resp_q   <= 128'd0;
            tout_q   <= 1'b0;
            crcerr_q <= 1'b0;
            syn_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            pre_q    <= pre_d;
            cmd_q    <= cmd_d;
            type_q   <= type_d;
            tx_q     <= tx_d;
            crc_q    <= crc_d;
            oe_q     <= oe_d;
            out_q    <= out_d;
            resp_q   <= resp_d;
            tout_q   <= tout_d;
            crcerr_q <= crcerr_d;
            syn_q    <= syn_d;
            busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q   <= (state_d == S_DONE);
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = tout_q;
    assign crcerr  = crcerr_q;
    assign syntaxe = syn_q;
    assign resp    = resp_q;

endmodule

// File: tb/tb_sdcmd_engine.sv
// tb_sdcmd_engine: directed bench for sdcmd_engine with a small card model
// that captures the command stream and drives hand-built responses.
module tb_sdcmd_engine;

    logic         clk = 1'b0;
    logic         rstn;
    logic         sdclk;
    wire          sdcmd;
    logic         dat0;
    logic [15:0]  clkdiv;
    logic         start;
    logic [15:0]  precnt;
    logic [5:0]   cmd;
    logic [31:0]  arg;
    logic [1:0]   resp_type;
    logic         busy, done, timeout, crcerr, syntaxe;
    logic [127:0] resp;
    logic         card_oe, card_bit;

    int n_tests = 0;
    int n_fail  = 0;
    int rises = 0, falls = 0, cyc = 0, done_cnt = 0;
    int s_rises;
    logic [3:0]   s_flags;
    logic         s_dat0;

    always #5 clk = ~clk;

    assign sdcmd = card_oe ? card_bit : 1'bz;
    pullup (sdcmd);

    sdcmd_engine dut (
        .rstn(rstn), .clk(clk), .sdclk(sdclk), .sdcmd(sdcmd), .dat0(dat0),
        .clkdiv(clkdiv), .start(start), .precnt(precnt), .cmd(cmd), .arg(arg),
        .resp_type(resp_type), .busy(busy), .done(done), .timeout(timeout),
        .crcerr(crcerr), .syntaxe(syntaxe), .resp(resp)
    );

    always @(posedge sdclk) rises++;
    always @(negedge sdclk) falls++;
    always @(posedge clk) cyc++;

    // Snapshot everything of interest in the done cycle.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            s_flags = {busy, timeout, crcerr, syntaxe};
            s_rises = rises;
            s_dat0  = dat0;
        end
    end

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] tb_crc7(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = hi; i >= lo; i--) begin
            fb = c[6] ^ v[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] a);
        logic [135:0] f;
        f = {88'd0, 2'b00, idx, a, 7'd0, 1'b1};
        f[7:1] = tb_crc7(f, 47, 8);
        return f;
    endfunction

    task automatic launch(input logic [5:0] c, input logic [31:0] a, input logic [1:0] t,
                          input logic [15:0] p, output int f0, output int d0);
        @(negedge clk);
        cmd = c; arg = a; resp_type = t; precnt = p; start = 1'b1;
        f0 = falls; d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collect the 48 command bits on sdclk rising edges; fd = falls to start bit.
    task automatic capture(input int f0, output logic [47:0] fr, output int fd);
        int guard;
        guard = 0;
        fr = 48'd0;
        @(posedge sdclk);
        while (sdcmd !== 1'b0 && guard < 300) begin
            @(posedge sdclk);
            guard++;
        end
        fd = falls - f0;
        fr[47] = sdcmd;
        for (int i = 46; i >= 0; i--) begin
            @(posedge sdclk);
            fr[i] = sdcmd;
        end
    endtask

    task automatic card_reply(input logic [135:0] bits, input int len);
        @(negedge sdclk);
        @(negedge sdclk);
        card_oe = 1'b1;
        for (int i = len - 1; i >= 0; i--) begin
            card_bit = bits[i];
            @(negedge sdclk);
        end
        card_oe = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int f0, d0, fd, t0, r_end;
        logic [47:0] fr;
        logic ok;
        logic [119:0] cid;
        logic [135:0] lf;

        rstn = 1'b0; start = 1'b0; cmd = 6'd0; arg = 32'd0; resp_type = 2'd0;
        precnt = 16'd0; clkdiv = 16'd2; dat0 = 1'b1; card_oe = 1'b0; card_bit = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {sdclk, busy, done, timeout, crcerr, syntaxe, sdcmd}, 7'b0000001);
        check_eq("reset_resp", resp, 128'd0);
        rstn = 1'b1;

        // sdclk period = 2*(clkdiv+1) clk cycles
        repeat (2) @(posedge sdclk);
        t0 = cyc;
        @(posedge sdclk);
        check_eq("period_div2", cyc - t0, 6);
        clkdiv = 16'd1;
        repeat (3) @(posedge sdclk);
        t0 = cyc;
        @(posedge sdclk);
        check_eq("period_div1", cyc - t0, 4);

        // CMD0, no response
        launch(6'd0, 32'd0, 2'd0, 16'd0, f0, d0);
        check_eq("cmd0_busy", busy, 1'b1);
        capture(f0, fr, fd);
        check_eq("cmd0_frame", fr, 48'h400000000095);
        check_eq("cmd0_startfall", fd, 1);
        wait_done(d0, 100, ok);
        check_eq("cmd0_done", ok, 1'b1);
        check_eq("cmd0_flags", s_flags, 4'b0000);
        repeat (4) @(negedge clk);
        check_eq("cmd0_one_pulse", done_cnt - d0, 1);

        // CMD8 short response, valid CRC
        launch(6'd8, 32'h1AA, 2'd1, 16'd0, f0, d0);
        capture(f0, fr, fd);
        check_eq("cmd8_frame", fr, 48'h48000001AA87);
        card_reply({88'd0, 48'h08000001AA13}, 48);
        wait_done(d0, 100, ok);
        check_eq("cmd8_done", ok, 1'b1);
        check_eq("cmd8_flags", s_flags, 4'b0000);
        check_eq("cmd8_resp", resp, {90'd0, 6'h08, 32'h1AA});

        // No card reply: timeout after 250 rises following the end bit
        launch(6'd8, 32'h1AA, 2'd1, 16'd0, f0, d0);
        capture(f0, fr, fd);
        @(negedge clk);
        r_end = rises;
        wait_done(d0, 3000, ok);
        check_eq("to_done", ok, 1'b1);
        check_eq("to_flags", s_flags, 4'b0100);
        check_eq("to_rises", s_rises - r_end, 250);
        check_eq("to_resp_held", resp, {90'd0, 6'h08, 32'h1AA});

        // Flipped argument bit: CRC error only
        launch(6'd8, 32'h1AA, 2'd1, 16'd0, f0, d0);
        capture(f0, fr, fd);
        card_reply({88'd0, 48'h08000001AB13}, 48);
        wait_done(d0, 100, ok);
        check_eq("crcerr_flags", {ok, s_flags}, 5'b10010);
        check_eq("crcerr_resp", resp, {90'd0, 6'h08, 32'h1AB});

        // Wrong index with a valid CRC: syntax error only
        launch(6'd8, 32'h1AA, 2'd1, 16'd0, f0, d0);
        capture(f0, fr, fd);
        card_reply(mk_short(6'h09, 32'h1AA), 48);
        wait_done(d0, 100, ok);
        check_eq("syn_flags", {ok, s_flags}, 5'b10001);

        // CMD2 long response (CID)
        cid = 120'h035344534231364780123456780012;
        lf = {8'h3F, cid, 7'd0, 1'b1};
        lf[7:1] = tb_crc7(lf, 127, 8);
        launch(6'd2, 32'd0, 2'd2, 16'd0, f0, d0);
        capture(f0, fr, fd);
        card_reply(lf, 136);
        wait_done(d0, 100, ok);
        check_eq("cid_flags", {ok, s_flags}, 5'b10000);
        check_eq("cid_resp", resp, {lf[127:1], 1'b0});

        // CMD7 R1b with precnt=8; DAT0 held low for 100 rises
        dat0 = 1'b0;
        launch(6'd7, 32'h00010000, 2'd3, 16'd8, f0, d0);
        capture(f0, fr, fd);
        check_eq("cmd7_startfall", fd, 9);
        card_reply(mk_short(6'h07, 32'h00000700), 48);
        repeat (100) @(posedge sdclk);
        check_eq("busy_hold", done_cnt - d0, 0);
        @(negedge sdclk);
        dat0 = 1'b1;
        wait_done(d0, 100, ok);
        check_eq("busy_done", {ok, s_dat0, s_flags}, 6'b110000);
        check_eq("busy_resp", resp, {90'd0, 6'h07, 32'h700});

        // Reset in the middle of SEND
        launch(6'd0, 32'd0, 2'd0, 16'd0, f0, d0);
        repeat (10) @(posedge sdclk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("midrst_outs", {sdclk, busy, done, timeout, crcerr, syntaxe, sdcmd}, 7'b0000001);
        check_eq("midrst_resp", resp, 128'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("midrst_no_done", done_cnt - d0, 0);

        launch(6'd0, 32'd0, 2'd0, 16'd0, f0, d0);
        capture(f0, fr, fd);
        check_eq("post_rst_frame", fr, 48'h400000000095);
        wait_done(d0, 100, ok);
        check_eq("post_rst_done", {ok, s_flags}, 5'b10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
